// File: rtl/cursor_pkg.sv
// -----------------------------------------------------------------------------
// cursor_pkg
// Shared types, default sizes and helpers for the edit-cursor controller.
//   dir_t       : key direction, also used as the index of the per-key buses
//   DEF_*       : default matrix size and auto-repeat timing
//   wrap_step() : modulo step of one cursor axis with opposing-key cancel
// Optional feature macro used by this slice: CURSOR_AUTOREPEAT_EN
// -----------------------------------------------------------------------------
package cursor_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int NUM_DIRS          = 4;
    localparam int DEF_ROWS          = 16;
    localparam int DEF_COLS          = 16;
    localparam int DEF_REPEAT_DELAY  = 25_000_000;
    localparam int DEF_REPEAT_PERIOD = 5_000_000;
    localparam int DEF_ROW_W         = $clog2(DEF_ROWS);
    localparam int DEF_COL_W         = $clog2(DEF_COLS);

    // One step of a cursor axis. dec/inc together cancel; wrapping is modulo
    // size (not modulo 2^width) so non-power-of-two matrices wrap correctly.
    function automatic int unsigned wrap_step(
        input int unsigned idx,
        input int unsigned size,
        input logic        dec,
        input logic        inc
    );
        int unsigned res;
        if (dec && !inc) begin
            res = (idx == 32'd0) ? (size - 32'd1) : (idx - 32'd1);
        end else if (inc && !dec) begin
            res = (idx == (size - 32'd1)) ? 32'd0 : (idx + 32'd1);
        end else begin
            res = idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/cursor_controller_key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Conditions one raw active-low push-button into a one-cycle step pulse.
//   Clock   : system clock
//   Reset_n : asynchronous active-low reset
//   key_n   : raw asynchronous key, 0 = pressed
//   run     : 1 = simulation running (only stops the repeat counter here;
//             step gating itself is done in the top level)
//   step    : one-cycle pulse per press (plus repeat pulses when enabled)
// Macro CURSOR_AUTOREPEAT_EN adds a hold counter generating repeat pulses
// after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
// -----------------------------------------------------------------------------
module key_conditioner
    import cursor_pkg::*;
#(
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic key_n,
    input  logic run,
    output logic step
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic press_s;

    // Two-flop synchronizer plus previous-value flop; all reset to released
    // so that reset release itself never looks like a press.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            prev_r  <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Falling edge of the synchronized key.
    assign press_s = prev_r & ~sync2_r;

`ifdef CURSOR_AUTOREPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             repeating_r;
    logic             rep_s;

    // Repeat fires at the initial delay, then (once repeating) every period.
    always_comb begin
        rep_s = 1'b0;
        if (!sync2_r && !run) begin
            if (repeating_r) begin
                rep_s = (cnt_r == CNT_W'(REPEAT_PERIOD));
            end else begin
                rep_s = (cnt_r == CNT_W'(REPEAT_DELAY));
            end
        end else begin
            rep_s = 1'b0;
        end
    end

    // Hold counter: counts while held in edit mode, clears on release or run.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            repeating_r <= 1'b0;
        end else if (sync2_r || run) begin
            cnt_r       <= {CNT_W{1'b0}};
            repeating_r <= 1'b0;
        end else if (rep_s) begin
            cnt_r       <= {{(CNT_W-1){1'b0}}, 1'b1};
            repeating_r <= 1'b1;
        end else begin
            cnt_r       <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            repeating_r <= repeating_r;
        end
    end

    assign step = press_s | rep_s;
`else
    // Without auto-repeat the run input and timing parameters have no effect.
    logic unused_cfg_s;
    assign unused_cfg_s = run | (REPEAT_DELAY == 0) | (REPEAT_PERIOD == 0);

    assign step = press_s;
`endif

endmodule

// File: rtl/cursor_controller.sv
// -----------------------------------------------------------------------------
// cursor_controller
// Edit cursor for the Game of Life LED matrix: four active-low keys move a
// row/column cursor (with modulo wrap) and one-hot select buses tell each dot
// cell whether it is the one being edited. Movement is frozen while Run = 1.
//   Clock, Reset_n              : clock, asynchronous active-low reset
//   KeyUp_n/Down_n/Left_n/Right_n : raw push-buttons, 0 = pressed
//   Run                         : 1 = simulation running, cursor frozen
//   RowIdx, ColIdx              : binary cursor position
//   RowSelect, ColumnSelect     : one-hot decode of RowIdx / ColIdx
// Macro CURSOR_AUTOREPEAT_EN enables auto-repeat while a key is held.
// -----------------------------------------------------------------------------
module cursor_controller
    import cursor_pkg::*;
#(
    parameter int ROWS          = DEF_ROWS,
    parameter int COLS          = DEF_COLS,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     KeyUp_n,
    input  logic                     KeyDown_n,
    input  logic                     KeyLeft_n,
    input  logic                     KeyRight_n,
    input  logic                     Run,
    output logic [$clog2(ROWS)-1:0]  RowIdx,
    output logic [$clog2(COLS)-1:0]  ColIdx,
    output logic [ROWS-1:0]          RowSelect,
    output logic [COLS-1:0]          ColumnSelect
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic [NUM_DIRS-1:0] keys_n_s;
    logic [NUM_DIRS-1:0] steps_s;
    logic                up_s;
    logic                down_s;
    logic                left_s;
    logic                right_s;

    logic [ROW_W-1:0]    row_idx_r;
    logic [COL_W-1:0]    col_idx_r;
    logic [ROWS-1:0]     row_sel_r;
    logic [COLS-1:0]     col_sel_r;
    logic [ROW_W-1:0]    row_nxt_s;
    logic [COL_W-1:0]    col_nxt_s;
    logic [ROWS-1:0]     row_sel_nxt_s;
    logic [COLS-1:0]     col_sel_nxt_s;

    assign keys_n_s[DIR_UP]    = KeyUp_n;
    assign keys_n_s[DIR_DOWN]  = KeyDown_n;
    assign keys_n_s[DIR_LEFT]  = KeyLeft_n;
    assign keys_n_s[DIR_RIGHT] = KeyRight_n;

    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_key
        key_conditioner #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_key (
            .Clock   (Clock),
            .Reset_n (Reset_n),
            .key_n   (keys_n_s[g]),
            .run     (Run),
            .step    (steps_s[g])
        );
    end

    // Steps only count in edit mode; opposing-key cancel is inside wrap_step.
    assign up_s    = steps_s[DIR_UP]    & ~Run;
    assign down_s  = steps_s[DIR_DOWN]  & ~Run;
    assign left_s  = steps_s[DIR_LEFT]  & ~Run;
    assign right_s = steps_s[DIR_RIGHT] & ~Run;

    // Next cursor position and its one-hot decode, axes independent.
    always_comb begin
        row_nxt_s     = ROW_W'(wrap_step(32'(row_idx_r), 32'(ROWS), up_s, down_s));
        col_nxt_s     = COL_W'(wrap_step(32'(col_idx_r), 32'(COLS), left_s, right_s));
        row_sel_nxt_s = {ROWS{1'b0}};
        col_sel_nxt_s = {COLS{1'b0}};
        row_sel_nxt_s[row_nxt_s] = 1'b1;
        col_sel_nxt_s[col_nxt_s] = 1'b1;
    end

    // Cursor registers; selects are registered alongside the index so both
    // change on the same edge and are always exactly one-hot.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            row_idx_r <= {ROW_W{1'b0}};
            col_idx_r <= {COL_W{1'b0}};
            row_sel_r <= {{(ROWS-1){1'b0}}, 1'b1};
            col_sel_r <= {{(COLS-1){1'b0}}, 1'b1};
        end else begin
            row_idx_r <= row_nxt_s;
            col_idx_r <= col_nxt_s;
            row_sel_r <= row_sel_nxt_s;
            col_sel_r <= col_sel_nxt_s;
        end
    end

    assign RowIdx       = row_idx_r;
    assign ColIdx       = col_idx_r;
    assign RowSelect    = row_sel_r;
    assign ColumnSelect = col_sel_r;

endmodule
